// File: rtl/regfile_param.sv
// Parametrised register file with per-register pending bits, a write-to-read bypass,
// a per-register clear mask and two fixed debug taps of stored state.
module regfile_param #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int NUM_READ   = 2,
    parameter int ZERO_REG0  = 1,
    parameter int BYPASS     = 1,
    parameter int TAP_A      = 10,
    parameter int TAP_B      = 12
) (
    input  logic                             clock,
    input  logic                             ctrl_reset,
    input  logic                             ctrl_writeEnable,
    input  logic [ADDR_WIDTH-1:0]            ctrl_writeReg,
    input  logic [DATA_WIDTH-1:0]            data_writeReg,
    input  logic                             ctrl_reserveEnable,
    input  logic [ADDR_WIDTH-1:0]            ctrl_reserveReg,
    input  logic [(1<<ADDR_WIDTH)-1:0]       ctrl_clearMask,
    input  logic [NUM_READ*ADDR_WIDTH-1:0]   ctrl_readReg,
    output logic [NUM_READ*DATA_WIDTH-1:0]   data_readReg,
    output logic [NUM_READ-1:0]              read_pending,
    output logic [DATA_WIDTH-1:0]            tap_a_out,
    output logic [DATA_WIDTH-1:0]            tap_b_out,
    output logic [ADDR_WIDTH:0]              pending_count
);

    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam int CW    = ADDR_WIDTH + 1;
    localparam logic [ADDR_WIDTH-1:0] TAP_A_IDX = ADDR_WIDTH'(TAP_A);
    localparam logic [ADDR_WIDTH-1:0] TAP_B_IDX = ADDR_WIDTH'(TAP_B);

    logic [DATA_WIDTH-1:0] data_q [DEPTH];
    logic [DATA_WIDTH-1:0] data_d [DEPTH];
    logic [DEPTH-1:0]      pend_q, pend_d;
    logic [CW-1:0]         count_q, count_d;

    // Register 0 is read-only zero when ZERO_REG0 is set.
    function automatic logic is_writable(input logic [ADDR_WIDTH-1:0] a);
        return !((ZERO_REG0 != 0) && (a == '0));
    endfunction

    always_comb begin
        count_d = '0;
        for (int i = 0; i < DEPTH; i++) begin
            // NOTE: every next-state value gets a default before any branch, so no latch is inferred.
            data_d[i] = data_q[i];
            pend_d[i] = pend_q[i];
            if (!is_writable(ADDR_WIDTH'(i))) begin
                data_d[i] = '0;
                pend_d[i] = 1'b0;
            end else if (ctrl_clearMask[i]) begin
                data_d[i] = '0;
                pend_d[i] = 1'b0;
            end else begin
                if (ctrl_writeEnable && ctrl_writeReg == ADDR_WIDTH'(i)) begin
                    data_d[i] = data_writeReg;
                    pend_d[i] = 1'b0;
                end
                // A reserve in the same cycle as a write wins: a newer producer is in flight.
                if (ctrl_reserveEnable && ctrl_reserveReg == ADDR_WIDTH'(i)) begin
                    pend_d[i] = 1'b1;
                end
            end
        end
        for (int i = 0; i < DEPTH; i++) begin
            count_d = count_d + CW'(pend_d[i]);
        end
    end

    always_ff @(posedge clock) begin
        if (ctrl_reset) begin
            // NOTE: the array lives in flops, not RAM, so clearing it on reset is legal and required here.
            for (int i = 0; i < DEPTH; i++) begin
                data_q[i] <= '0;
            end
            pend_q  <= '0;
            count_q <= '0;
        end else begin
            // NOTE: sequential state is updated with non-blocking assignments only.
            data_q  <= data_d;
            pend_q  <= pend_d;
            count_q <= count_d;
        end
    end

    for (genvar p = 0; p < NUM_READ; p++) begin : g_read
        logic [ADDR_WIDTH-1:0] addr;
        logic                  hit;
        assign addr = ctrl_readReg[p*ADDR_WIDTH +: ADDR_WIDTH];
        // A same-cycle clear of the target suppresses forwarding of the write data.
        assign hit  = (BYPASS != 0) && ctrl_writeEnable && (ctrl_writeReg == addr)
                      && is_writable(addr) && !ctrl_clearMask[addr];
        assign data_readReg[p*DATA_WIDTH +: DATA_WIDTH] = hit ? data_writeReg : data_q[addr];
        assign read_pending[p] = hit ? 1'b0 : pend_q[addr];
    end

    assign tap_a_out     = data_q[TAP_A_IDX];
    assign tap_b_out     = data_q[TAP_B_IDX];
    assign pending_count = count_q;

endmodule

// File: tb/tb_regfile_param.sv
// Bench for regfile_param: a bypassing/zero-reg0 instance and a plain instance share stimulus
// and are both compared against an array-based model of the register-file rules.
module tb_regfile_param;

    localparam int DW    = 32;
    localparam int AW    = 5;
    localparam int NR    = 2;
    localparam int DEPTH = 32;

    logic             clock = 1'b0;
    logic             ctrl_reset;
    logic             we;
    logic [AW-1:0]    wr;
    logic [DW-1:0]    wd;
    logic             re;
    logic [AW-1:0]    rr;
    logic [DEPTH-1:0] clr;
    logic [AW-1:0]    ra [NR];
    logic [NR*AW-1:0] raddr;

    logic [NR*DW-1:0] rd_a, rd_b;
    logic [NR-1:0]    rp_a, rp_b;
    logic [DW-1:0]    tapa_a, tapb_a, tapa_b, tapb_b;
    logic [AW:0]      pc_a, pc_b;

    int errors = 0;
    int checks = 0;

    always #5 clock = ~clock;
    assign raddr = {ra[1], ra[0]};

    regfile_param dut (
        .clock(clock), .ctrl_reset(ctrl_reset), .ctrl_writeEnable(we), .ctrl_writeReg(wr),
        .data_writeReg(wd), .ctrl_reserveEnable(re), .ctrl_reserveReg(rr),
        .ctrl_clearMask(clr), .ctrl_readReg(raddr), .data_readReg(rd_a),
        .read_pending(rp_a), .tap_a_out(tapa_a), .tap_b_out(tapb_a), .pending_count(pc_a)
    );

    regfile_param #(.BYPASS(0), .ZERO_REG0(0)) dut_nb (
        .clock(clock), .ctrl_reset(ctrl_reset), .ctrl_writeEnable(we), .ctrl_writeReg(wr),
        .data_writeReg(wd), .ctrl_reserveEnable(re), .ctrl_reserveReg(rr),
        .ctrl_clearMask(clr), .ctrl_readReg(raddr), .data_readReg(rd_b),
        .read_pending(rp_b), .tap_a_out(tapa_b), .tap_b_out(tapb_b), .pending_count(pc_b)
    );

    // Model state: index 0 = default instance, index 1 = BYPASS=0/ZERO_REG0=0 instance.
    logic [DW-1:0] mem_m  [2][DEPTH];
    logic          pend_m [2][DEPTH];

    function automatic bit cfg_zero(int c); return c == 0; endfunction
    function automatic bit cfg_byp(int c);  return c == 0; endfunction

    // Apply one rising edge as a sequence of operations: write, reserve, then clear and reg0 override.
    task automatic model_edge();
        for (int c = 0; c < 2; c++) begin
            if (ctrl_reset) begin
                for (int i = 0; i < DEPTH; i++) begin
                    mem_m[c][i] = '0; pend_m[c][i] = 1'b0;
                end
            end else begin
                if (we) begin mem_m[c][wr] = wd; pend_m[c][wr] = 1'b0; end
                if (re) pend_m[c][rr] = 1'b1;
                for (int i = 0; i < DEPTH; i++)
                    if (clr[i]) begin mem_m[c][i] = '0; pend_m[c][i] = 1'b0; end
                if (cfg_zero(c)) begin mem_m[c][0] = '0; pend_m[c][0] = 1'b0; end
            end
        end
    endtask

    function automatic bit bypass_hit(int c, logic [AW-1:0] a);
        return cfg_byp(c) && we && (wr == a) && !(cfg_zero(c) && a == 0) && !clr[a];
    endfunction
    function automatic logic [DW-1:0] exp_data(int c, int p);
        return bypass_hit(c, ra[p]) ? wd : mem_m[c][ra[p]];
    endfunction
    function automatic logic exp_pend(int c, int p);
        return bypass_hit(c, ra[p]) ? 1'b0 : pend_m[c][ra[p]];
    endfunction
    function automatic logic [AW:0] exp_count(int c);
        int n = 0;
        for (int i = 0; i < DEPTH; i++) n += int'(pend_m[c][i]);
        return (AW+1)'(n);
    endfunction
    function automatic logic [DW-1:0] act_data(int c, int p);
        return (c == 0) ? rd_a[p*DW +: DW] : rd_b[p*DW +: DW];
    endfunction
    function automatic logic act_pend(int c, int p);
        return (c == 0) ? rp_a[p] : rp_b[p];
    endfunction
    function automatic logic [AW:0] act_count(int c);
        return (c == 0) ? pc_a : pc_b;
    endfunction

    task automatic idle();
        ctrl_reset = 1'b0; we = 1'b0; wr = '0; wd = '0;
        re = 1'b0; rr = '0; clr = '0; ra[0] = '0; ra[1] = '0;
    endtask

    // Inputs are driven on the falling edge; the model advances on the rising edge.
    task automatic tick();
        @(posedge clock);
        model_edge();
        @(negedge clock);
    endtask

    task automatic test_reset();
        idle();
        ctrl_reset = 1'b1; we = 1'b1; wr = 5'd9; wd = 32'hCAFE; re = 1'b1; rr = 5'd9;
        tick();
        idle();
        for (int a = 0; a < DEPTH; a++) begin
            ra[0] = AW'(a); ra[1] = AW'(DEPTH - 1 - a);
            #1;
            for (int c = 0; c < 2; c++)
                for (int p = 0; p < NR; p++) begin
                    checks++;
                    if (act_data(c, p) !== 32'h0 || act_pend(c, p) !== 1'b0) begin
                        errors++;
                        $display("FAIL reset_read c%0d p%0d addr %0d: got %h/%b want 0/0",
                                 c, p, ra[p], act_data(c, p), act_pend(c, p));
                    end
                end
        end
        checks++;
        if (pc_a !== 6'd0 || pc_b !== 6'd0 || tapa_a !== 0 || tapb_a !== 0 || tapa_b !== 0 || tapb_b !== 0) begin
            errors++;
            $display("FAIL reset_count_taps: counts %0d/%0d taps %h %h %h %h want all 0",
                     pc_a, pc_b, tapa_a, tapb_a, tapa_b, tapb_b);
        end
    endtask

    task automatic test_bypass();
        idle();
        we = 1'b1; wr = 5'd5; wd = 32'hDEADBEEF; ra[0] = 5'd5;
        #1;
        checks++;
        if (act_data(0, 0) !== 32'hDEADBEEF || act_pend(0, 0) !== 1'b0) begin
            errors++;
            $display("FAIL bypass_before_edge: got %h/%b want deadbeef/0", act_data(0, 0), act_pend(0, 0));
        end
        checks++;
        if (act_data(1, 0) !== 32'h0) begin
            errors++;
            $display("FAIL nobypass_before_edge: got %h want 0", act_data(1, 0));
        end
        tick();
        idle(); ra[0] = 5'd5; #1;
        checks++;
        if (act_data(0, 0) !== 32'hDEADBEEF || act_data(1, 0) !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL write_after_edge: got %h %h want deadbeef", act_data(0, 0), act_data(1, 0));
        end
    endtask

    task automatic test_reserve();
        idle();
        re = 1'b1; rr = 5'd7; ra[0] = 5'd7;
        tick();
        idle(); ra[0] = 5'd7; #1;
        checks++;
        if (act_pend(0, 0) !== 1'b1 || act_pend(1, 0) !== 1'b1 || pc_a !== 6'd1 || pc_b !== 6'd1) begin
            errors++;
            $display("FAIL reserve_r7: pend %b %b count %0d %0d want 1 1 1 1",
                     act_pend(0, 0), act_pend(1, 0), pc_a, pc_b);
        end
        we = 1'b1; wr = 5'd7; wd = 32'h1234; #1;
        checks++;
        if (act_data(0, 0) !== 32'h1234 || act_pend(0, 0) !== 1'b0 || act_pend(1, 0) !== 1'b1) begin
            errors++;
            $display("FAIL reserve_bypass: got %h/%b nb pend %b want 1234/0 nb 1",
                     act_data(0, 0), act_pend(0, 0), act_pend(1, 0));
        end
        tick();
        idle(); ra[0] = 5'd7; ra[1] = 5'd7; #1;
        checks++;
        if (act_data(0, 0) !== 32'h1234 || act_data(0, 1) !== 32'h1234 || act_pend(0, 1) !== 1'b0
            || pc_a !== 6'd0 || pc_b !== 6'd0) begin
            errors++;
            $display("FAIL write_clears_pending: got %h %h pend %b count %0d %0d want 1234 1234 0 0 0",
                     act_data(0, 0), act_data(0, 1), act_pend(0, 1), pc_a, pc_b);
        end
    endtask

    task automatic test_write_reserve_clear();
        idle();
        we = 1'b1; wr = 5'd3; wd = 32'h55; re = 1'b1; rr = 5'd3; ra[0] = 5'd3; #1;
        checks++;
        if (act_data(0, 0) !== 32'h55 || act_pend(0, 0) !== 1'b0) begin
            errors++;
            $display("FAIL wr_res_bypass: got %h/%b want 55/0", act_data(0, 0), act_pend(0, 0));
        end
        tick();
        idle(); ra[0] = 5'd3; #1;
        checks++;
        if (act_data(0, 0) !== 32'h55 || act_pend(0, 0) !== 1'b1 || act_pend(1, 0) !== 1'b1) begin
            errors++;
            $display("FAIL wr_res_after: got %h/%b nb %b want 55/1 nb 1", act_data(0, 0), act_pend(0, 0), act_pend(1, 0));
        end
        clr[3] = 1'b1; we = 1'b1; wr = 5'd3; wd = 32'h99; #1;
        checks++;
        if (act_data(0, 0) !== 32'h55 || act_pend(0, 0) !== 1'b1) begin
            errors++;
            $display("FAIL clear_suppresses_bypass: got %h/%b want 55/1", act_data(0, 0), act_pend(0, 0));
        end
        tick();
        idle(); ra[0] = 5'd3; #1;
        checks++;
        if (act_data(0, 0) !== 32'h0 || act_pend(0, 0) !== 1'b0 || act_data(1, 0) !== 32'h0) begin
            errors++;
            $display("FAIL clear_wins: got %h/%b nb %h want 0/0 nb 0", act_data(0, 0), act_pend(0, 0), act_data(1, 0));
        end
    endtask

    task automatic test_zero_taps();
        idle();
        we = 1'b1; wr = 5'd0; wd = 32'hFFFFFFFF; re = 1'b1; rr = 5'd0; #1;
        checks++;
        if (act_data(0, 0) !== 32'h0 || act_pend(0, 0) !== 1'b0) begin
            errors++;
            $display("FAIL reg0_no_bypass: got %h/%b want 0/0", act_data(0, 0), act_pend(0, 0));
        end
        tick();
        idle(); #1;
        checks++;
        if (act_data(0, 0) !== 32'h0 || act_pend(0, 0) !== 1'b0 || act_data(1, 0) !== 32'hFFFFFFFF
            || act_pend(1, 0) !== 1'b1) begin
            errors++;
            $display("FAIL reg0_hardwired: got %h/%b nb %h/%b want 0/0 nb ffffffff/1",
                     act_data(0, 0), act_pend(0, 0), act_data(1, 0), act_pend(1, 0));
        end
        we = 1'b1; wr = 5'd10; wd = 32'hA; #1;
        checks++;
        if (tapa_a !== 32'h0) begin
            errors++;
            $display("FAIL tap_not_bypassed: got %h want 0", tapa_a);
        end
        tick();
        we = 1'b1; wr = 5'd12; wd = 32'hB;
        tick();
        idle(); #1;
        checks++;
        if (tapa_a !== 32'hA || tapb_a !== 32'hB || tapa_b !== 32'hA || tapb_b !== 32'hB) begin
            errors++;
            $display("FAIL taps: got %h %h %h %h want a b a b", tapa_a, tapb_a, tapa_b, tapb_b);
        end
    endtask

    task automatic test_reset_midseq();
        idle();
        re = 1'b1;
        rr = 5'd1; tick();
        rr = 5'd2; tick();
        rr = 5'd4; tick();
        idle(); #1;
        checks++;
        if (pc_a !== exp_count(0) || pc_a !== 6'd3 || pc_b !== exp_count(1)) begin
            errors++;
            $display("FAIL three_reserved: got %0d %0d want %0d %0d", pc_a, pc_b, exp_count(0), exp_count(1));
        end
        ctrl_reset = 1'b1; we = 1'b1; wr = 5'd2; wd = 32'h7777; re = 1'b1; rr = 5'd6;
        tick();
        idle(); ra[0] = 5'd2; ra[1] = 5'd1; #1;
        checks++;
        if (pc_a !== 6'd0 || pc_b !== 6'd0 || act_data(0, 0) !== 32'h0 || act_data(1, 0) !== 32'h0
            || act_pend(0, 1) !== 1'b0 || tapa_a !== 32'h0) begin
            errors++;
            $display("FAIL reset_midseq: count %0d %0d r2 %h %h r1 pend %b tap %h want all 0",
                     pc_a, pc_b, act_data(0, 0), act_data(1, 0), act_pend(0, 1), tapa_a);
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            ctrl_reset = ($urandom_range(0, 59) == 0);
            we  = $urandom_range(0, 1) == 1;
            wr  = AW'($urandom_range(0, DEPTH - 1));
            wd  = $urandom;
            re  = $urandom_range(0, 2) == 0;
            rr  = ($urandom_range(0, 3) == 0) ? wr : AW'($urandom_range(0, DEPTH - 1));
            clr = ($urandom_range(0, 4) == 0) ? (DEPTH'(1) << $urandom_range(0, DEPTH - 1)) : '0;
            if ($urandom_range(0, 3) == 0) clr[wr] = 1'b1;
            for (int p = 0; p < NR; p++)
                ra[p] = ($urandom_range(0, 1) == 1) ? wr : AW'($urandom_range(0, DEPTH - 1));
            #1;
            for (int c = 0; c < 2; c++) begin
                for (int p = 0; p < NR; p++) begin
                    checks++;
                    if (act_data(c, p) !== exp_data(c, p) || act_pend(c, p) !== exp_pend(c, p)) begin
                        errors++;
                        $display("FAIL random_read n%0d c%0d p%0d addr %0d: got %h/%b want %h/%b",
                                 n, c, p, ra[p], act_data(c, p), act_pend(c, p), exp_data(c, p), exp_pend(c, p));
                    end
                end
                checks++;
                if (act_count(c) !== exp_count(c)) begin
                    errors++;
                    $display("FAIL random_count n%0d c%0d: got %0d want %0d", n, c, act_count(c), exp_count(c));
                end
            end
            checks++;
            if (tapa_a !== mem_m[0][10] || tapb_a !== mem_m[0][12] || tapa_b !== mem_m[1][10] || tapb_b !== mem_m[1][12]) begin
                errors++;
                $display("FAIL random_taps n%0d: got %h %h %h %h want %h %h %h %h", n, tapa_a, tapb_a,
                         tapa_b, tapb_b, mem_m[0][10], mem_m[0][12], mem_m[1][10], mem_m[1][12]);
            end
            tick();
        end
    endtask

    initial begin
        for (int c = 0; c < 2; c++)
            for (int i = 0; i < DEPTH; i++) begin
                mem_m[c][i] = '0; pend_m[c][i] = 1'b0;
            end
        idle();
        @(negedge clock);
        test_reset();
        test_bypass();
        test_reserve();
        test_write_reserve_clear();
        test_zero_taps();
        test_reset_midseq();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
